fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the pipelined RV32I core.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: default parameters,
// bubble encoding and the per-cycle action select.
package fetch_stage_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          CNT_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    // Redirect always wins over a load-use stall.
    function automatic fetch_act_e sel_act(input logic redirect, input logic hazard);
        if (redirect)
            return ACT_REDIRECT;
        else if (hazard)
            return ACT_STALL;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load enable, synchronous flush to a bubble,
// asynchronous active-low reset to the same bubble.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (en_i) begin
            if (flush_i) begin
                pc_d    = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_i;
                instr_d = instr_i;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the pipelined RV32I core: PC register, next-PC select,
// saturating stall counter and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF[XLEN-1:0],
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF,
    parameter int              CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_MSK = ~XLEN'(3);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    fetch_act_e       act;
    logic [XLEN-1:0]  pc_q,  pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign act = sel_act(redirect, hazard);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        unique case (act)
            // Low target bits are dropped: fetch is always word aligned.
            ACT_REDIRECT: pc_d = redirect_target & ALIGN_MSK;
            ACT_STALL: begin
                if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default:      pc_d = pc_q + PC_STEP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    fetch_stage_if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .en_i    (act != ACT_STALL),
        .flush_i (act == ACT_REDIRECT),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign stall_count = cnt_q;

endmodule
